// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multi-cycle RV32 main control FSM
// Purpose: sequences fetch/decode/execute/memory/writeback for the RV32 datapath.
//   Drives ALU control, mux selects and write enables, and handshakes with one
//   shared memory port. Counts retired instructions. Traps on an illegal opcode
//   or a memory timeout.
// Ports:
//   clk, reset (sync, active-high); opcode (IR[6:0]); zero (ALU flag);
//   mem_ready / mem_req, mem_we, iord (memory port); ir_we, pc_we, pc_src (PC/IR);
//   alu_src_a, alu_src_b, alu_op, f7_en (ALU); reg_we, mem_to_reg (writeback);
//   trap, trap_cause (sticky trap); state (debug); retired (retire counter).
module rv_multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             f7_en,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  // wait_cnt only ever reaches TIMEOUT-1 before the FSM leaves the state
  localparam int            WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        st_q, st_d;
  logic [WW-1:0] wait_cnt;
  logic [12:0]   ctrl_q;
  logic          retire;
  logic          trap_set;
  logic [1:0]    trap_set_cause;
  logic          timed_out;

  // Moore control word:
  // {mem_req, mem_we, iord, pc_src, alu_src_a, alu_src_b, alu_op, f7_en, reg_we, mem_to_reg}
  function automatic logic [12:0] moore(input state_t s);
    logic [12:0] c;
    c = '0;
    case (s)
      S_FETCH:  c = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
      S_DECODE: c = {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
      S_MEMADR: c = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
      S_MEMRD:  c = {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      S_MEMWB:  c = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
      S_MEMWR:  c = {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      S_EXEC_R: c = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
      S_EXEC_I: c = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
      S_ALUWB:  c = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
      S_BRANCH: c = {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
      default:  c = '0;
    endcase
    return c;
  endfunction

  // A completing access (mem_ready) always beats the timeout on the same cycle.
  assign timed_out = !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    st_d           = st_q;
    retire         = 1'b0;
    trap_set       = 1'b0;
    trap_set_cause = 2'b00;
    case (st_q)
      S_FETCH: begin
        if (mem_ready) begin
          st_d = S_DECODE;
        end else if (timed_out) begin
          st_d = S_TRAP; trap_set = 1'b1; trap_set_cause = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: st_d = S_MEMADR;
          7'b0110011:             st_d = S_EXEC_R;
          7'b0010011:             st_d = S_EXEC_I;
          7'b1100011:             st_d = S_BRANCH;
          default: begin
            st_d = S_TRAP; trap_set = 1'b1; trap_set_cause = 2'b01;
          end
        endcase
      end
      S_MEMADR: st_d = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          st_d = S_MEMWB;
        end else if (timed_out) begin
          st_d = S_TRAP; trap_set = 1'b1; trap_set_cause = 2'b10;
        end
      end
      S_MEMWB: begin st_d = S_FETCH; retire = 1'b1; end
      S_MEMWR: begin
        if (mem_ready) begin
          st_d = S_FETCH; retire = 1'b1;
        end else if (timed_out) begin
          st_d = S_TRAP; trap_set = 1'b1; trap_set_cause = 2'b10;
        end
      end
      S_EXEC_R: st_d = S_ALUWB;
      S_EXEC_I: st_d = S_ALUWB;
      S_ALUWB:  begin st_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin st_d = S_FETCH; retire = 1'b1; end
      S_TRAP:   st_d = S_TRAP;
      default: begin
        st_d = S_TRAP; trap_set = 1'b1; trap_set_cause = 2'b01;
      end
    endcase
  end

  // Control word is registered from the next state so it lines up with st_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= S_FETCH;
      ctrl_q     <= moore(S_FETCH);
      retired    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      st_q   <= st_d;
      ctrl_q <= moore(st_d);
      if (retire) retired <= retired + 1'b1;
      if (trap_set) begin
        trap       <= 1'b1;
        trap_cause <= trap_set_cause;
      end
      if ((st_d == st_q) && !mem_ready &&
          (st_q == S_FETCH || st_q == S_MEMRD || st_q == S_MEMWR))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Reset forces every enable and request low in the same cycle.
  assign {mem_req, mem_we, iord, pc_src, alu_src_a, alu_src_b, alu_op,
          f7_en, reg_we, mem_to_reg} = reset ? '0 : ctrl_q;
  assign ir_we = !reset && (st_q == S_FETCH) && mem_ready;
  assign pc_we = !reset && (((st_q == S_FETCH) && mem_ready) ||
                            ((st_q == S_BRANCH) && zero));
  assign state = st_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - self-checking bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, iord, ir_we, pc_we, pc_src, f7_en, reg_we, mem_to_reg, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, trap_cause;
  logic [3:0] state, retired;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .f7_en(f7_en), .reg_we(reg_we), .mem_to_reg(mem_to_reg), .trap(trap),
    .trap_cause(trap_cause), .state(state), .retired(retired)
  );

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;
  // enable/request bits of the 15-bit control word checked while reset=1
  localparam logic [14:0] EN_MASK = 15'b110110000000010;

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       zero;
    logic       rdy;
    logic [3:0] st;
    logic [3:0] ret;
    logic       trap;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] m_ret;
  logic       m_trap;
  logic [1:0] m_cause;

  // One row per clock: inputs, state expected during the cycle, and whether
  // the closing edge retires (rt) or enters TRAP with cause tc.
  task automatic add(input logic r, input logic [6:0] o, input logic z, input logic rd,
                     input logic [3:0] s, input logic rt, input logic [1:0] tc);
    vec_t v;
    v.rst = r; v.opc = o; v.zero = z; v.rdy = rd; v.st = s;
    v.ret = m_ret; v.trap = m_trap; v.cause = m_cause;
    tbl.push_back(v);
    if (r) begin
      m_ret = 4'd0; m_trap = 1'b0; m_cause = 2'b00;
    end else begin
      if (rt) m_ret = m_ret + 4'd1;
      if (tc != 2'b00) begin m_trap = 1'b1; m_cause = tc; end
    end
  endtask

  // {mem_req, mem_we, iord, ir_we, pc_we, pc_src, a, b, op, f7_en, reg_we, mem_to_reg}
  function automatic logic [14:0] exp_ctrl(input logic [3:0] s, input logic rdy, input logic z);
    logic [14:0] c;
    c = '0;
    case (s)
      4'd0: c = {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000};
      4'd1: c = {6'b000000, 2'b10, 2'b10, 2'b00, 3'b000};
      4'd2: c = {6'b000000, 2'b01, 2'b10, 2'b00, 3'b000};
      4'd3: c = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000};
      4'd4: c = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b011};
      4'd5: c = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000};
      4'd6: c = {6'b000000, 2'b01, 2'b00, 2'b10, 3'b100};
      4'd7: c = {6'b000000, 2'b01, 2'b10, 2'b10, 3'b000};
      4'd8: c = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b010};
      4'd9: c = {1'b0, 1'b0, 1'b0, 1'b0, z, 1'b1, 2'b01, 2'b00, 2'b01, 3'b000};
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic [14:0] actc, expc, mask;

    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    m_ret = 4'd0; m_trap = 1'b0; m_cause = 2'b00;

    add(1, OP_ADD, 0, 0, 4'd0, 0, 2'b00);
    // add, zero-wait: 0,1,6,8
    add(0, OP_ADD, 0, 1, 4'd0, 0, 2'b00); add(0, OP_ADD, 0, 1, 4'd1, 0, 2'b00);
    add(0, OP_ADD, 0, 1, 4'd6, 0, 2'b00); add(0, OP_ADD, 0, 1, 4'd8, 1, 2'b00);
    // lw with three wait cycles in MEMRD: 8 cycles total
    add(0, OP_LW, 0, 1, 4'd0, 0, 2'b00); add(0, OP_LW, 0, 1, 4'd1, 0, 2'b00);
    add(0, OP_LW, 0, 1, 4'd2, 0, 2'b00);
    for (int k = 0; k < 3; k++) add(0, OP_LW, 0, 0, 4'd3, 0, 2'b00);
    add(0, OP_LW, 0, 1, 4'd3, 0, 2'b00); add(0, OP_LW, 0, 1, 4'd4, 1, 2'b00);
    // beq taken, then not taken
    add(0, OP_BEQ, 1, 1, 4'd0, 0, 2'b00); add(0, OP_BEQ, 1, 1, 4'd1, 0, 2'b00);
    add(0, OP_BEQ, 1, 1, 4'd9, 1, 2'b00);
    add(0, OP_BEQ, 0, 1, 4'd0, 0, 2'b00); add(0, OP_BEQ, 0, 1, 4'd1, 0, 2'b00);
    add(0, OP_BEQ, 0, 1, 4'd9, 1, 2'b00);
    // sw, zero-wait
    add(0, OP_SW, 0, 1, 4'd0, 0, 2'b00); add(0, OP_SW, 0, 1, 4'd1, 0, 2'b00);
    add(0, OP_SW, 0, 1, 4'd2, 0, 2'b00); add(0, OP_SW, 0, 1, 4'd5, 1, 2'b00);
    // addi whose fetch completes on the last tolerated wait cycle
    for (int k = 0; k < 3; k++) add(0, OP_ADDI, 0, 0, 4'd0, 0, 2'b00);
    add(0, OP_ADDI, 0, 1, 4'd0, 0, 2'b00); add(0, OP_ADDI, 0, 1, 4'd1, 0, 2'b00);
    add(0, OP_ADDI, 0, 1, 4'd7, 0, 2'b00); add(0, OP_ADDI, 0, 1, 4'd8, 1, 2'b00);
    // ten more addi: retired climbs to 15 and wraps to 0
    for (int k = 0; k < 10; k++) begin
      add(0, OP_ADDI, 0, 1, 4'd0, 0, 2'b00); add(0, OP_ADDI, 0, 1, 4'd1, 0, 2'b00);
      add(0, OP_ADDI, 0, 1, 4'd7, 0, 2'b00); add(0, OP_ADDI, 0, 1, 4'd8, 1, 2'b00);
    end
    // sw interrupted by reset while waiting in MEMWR
    add(0, OP_SW, 0, 1, 4'd0, 0, 2'b00); add(0, OP_SW, 0, 1, 4'd1, 0, 2'b00);
    add(0, OP_SW, 0, 1, 4'd2, 0, 2'b00); add(0, OP_SW, 0, 0, 4'd5, 0, 2'b00);
    add(1, OP_SW, 0, 0, 4'd5, 0, 2'b00);
    // fetch timeout after four stalled cycles; mem_ready ignored in TRAP
    for (int k = 0; k < 3; k++) add(0, OP_SW, 0, 0, 4'd0, 0, 2'b00);
    add(0, OP_SW, 0, 0, 4'd0, 0, 2'b10);
    add(0, OP_SW, 0, 1, 4'd10, 0, 2'b00); add(0, OP_SW, 0, 1, 4'd10, 0, 2'b00);
    add(1, OP_SW, 0, 1, 4'd10, 0, 2'b00);
    // illegal opcode, then reset out of TRAP
    add(0, OP_BAD, 0, 1, 4'd0, 0, 2'b00); add(0, OP_BAD, 0, 1, 4'd1, 0, 2'b01);
    add(0, OP_BAD, 0, 1, 4'd10, 0, 2'b00); add(0, OP_BAD, 0, 1, 4'd10, 0, 2'b00);
    add(1, OP_BAD, 0, 0, 4'd10, 0, 2'b00); add(0, OP_BAD, 0, 0, 4'd0, 0, 2'b00);

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; opcode = tbl[i].opc; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
      #2;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", i, 32'd0, 32'd1);
      end else begin
        v    = sb.pop_front();
        actc = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                alu_op, f7_en, reg_we, mem_to_reg};
        expc = v.rst ? 15'd0 : exp_ctrl(v.st, v.rdy, v.zero);
        mask = v.rst ? EN_MASK : 15'h7fff;
        chk("state",   i, 32'(state),   32'(v.st));
        chk("ctrl",    i, 32'(actc & mask), 32'(expc & mask));
        chk("retired", i, 32'(retired), 32'(v.ret));
        chk("trap",    i, 32'({trap, trap_cause}), 32'({v.trap, v.cause}));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
